lsu_mem_ctrl: RTL

//  Load/store memory controller between EX/MEM and the data memory port. Accepts one

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_mem_ctrl_store_align.sv | 52 +++++
 rtl/lsu_mem_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store memory controller.
//               It holds the RV32I funct3 width codes, the controller state
//               encoding, and a helper that returns which address bits must
//               be zero for a given access width.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

   // RV32I load width codes
   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;

   // RV32I store width codes
   localparam logic [2:0] c_f3_sb  = 3'b000;
   localparam logic [2:0] c_f3_sh  = 3'b001;
   localparam logic [2:0] c_f3_sw  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } lsu_state_t;

   // Address bits that must be zero for a naturally aligned access.
   // funct3[1:0] carries the size for both loads and stores; the unsigned
   // bit (funct3[2]) does not change the size.
   function automatic logic [1:0] f3_lo_mask(input logic [2:0] f3);
      logic [1:0] mask;
      case (f3[1:0])
         c_f3_sb[1:0]: mask = 2'b00;
         c_f3_sh[1:0]: mask = 2'b01;
         default:      mask = 2'b11;
      endcase
      return mask;
   endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_mem_ctrl_store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Combinational byte-lane steering for stores. Produces the
//               byte write strobes, the lane-replicated write data and the
//               misalignment flag for an access.
// Ports       : funct3   in  3   access width code
//               addr_lo  in  2   byte offset inside the word
//               rs2      in  32  store source register
//               is_store in  1   1 = store; loads get zero strobes/data
//               wstrb    out 4   byte-lane write enables
//               wdata    out 32  replicated store data
//               misalign out 1   access crosses its natural alignment
// Revision    : 1.0  initial release
// ============================================================================
module store_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic        is_store,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misalign
);

   always_comb begin
      wstrb = 4'b0000;
      wdata = 32'h0000_0000;
      if (is_store) begin
         case (funct3[1:0])
            c_f3_sb[1:0]: begin
               wstrb = 4'b0001 << addr_lo;
               wdata = {4{rs2[7:0]}};
            end
            c_f3_sh[1:0]: begin
               wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata = {2{rs2[15:0]}};
            end
            default: begin
               wstrb = 4'b1111;
               wdata = rs2;
            end
         endcase
      end
   end

   assign misalign = |(addr_lo & f3_lo_mask(funct3));

endmodule : store_align
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store controller between the MEM stage and the data
//               memory port. Accepts one access per handshake, drives a
//               held request until grant, waits for read data on loads and
//               returns a one-cycle completion pulse carrying the raw word.
//               Accesses that never complete are aborted with bus_err.
// Parameters  : TIMEOUT_CYCLES  cycles spent in REQ+WAIT before abort
// Ports       : clk, rst_n (async active-low)
//               req_*  request from the MEM stage, req_ready high in IDLE
//               dm_*   data memory request / grant / read-data port
//               rsp_*  completion pulse, read word, funct3, addr[1:0], type
//               misalign, bus_err  status qualified by rsp_valid
//               stall  pipeline hold while an access is in flight
// Revision    : 1.0  initial release
// ============================================================================
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_mem_read,
   input  logic        req_mem_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_wstrb,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [2:0]  rsp_funct3,
   output logic [1:0]  rsp_addr_lo,
   output logic        rsp_mem_read,
   output logic        misalign,
   output logic        bus_err,
   output logic        stall
);

   // Counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES:
   // a load granted on the last allowed cycle spends one more WAIT cycle
   // before it can be aborted, so the count may reach TIMEOUT_CYCLES.
   localparam int c_cnt_raw = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_cnt_w   = (c_cnt_raw > 8) ? c_cnt_raw : 8;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   lsu_state_t         r_state;
   logic [c_cnt_w-1:0] r_cnt;

   logic               w_accept;
   logic               w_is_load;
   logic               w_is_store;
   logic               w_misalign;
   logic               w_timeout;
   logic [3:0]         w_wstrb;
   logic [31:0]        w_wdata;

   // Both read and write set is treated as a load.
   assign w_is_load  = req_mem_read;
   assign w_is_store = ~req_mem_read;
   assign w_accept   = (r_state == ST_IDLE) && req_valid && (req_mem_read || req_mem_write);
   assign w_timeout  = (r_cnt >= c_cnt_last);

   assign req_ready  = (r_state == ST_IDLE);
   assign stall      = (r_state != ST_IDLE);

   store_align u_store_align (
      .funct3   (req_funct3),
      .addr_lo  (req_addr[1:0]),
      .rs2      (req_wdata),
      .is_store (w_is_store),
      .wstrb    (w_wstrb),
      .wdata    (w_wdata),
      .misalign (w_misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         dm_req       <= 1'b0;
         dm_we        <= 1'b0;
         dm_addr      <= 32'h0;
         dm_wstrb     <= 4'b0000;
         dm_wdata     <= 32'h0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 32'h0;
         rsp_funct3   <= 3'b000;
         rsp_addr_lo  <= 2'b00;
         rsp_mem_read <= 1'b0;
         misalign     <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cnt        <= '0;
                  rsp_funct3   <= req_funct3;
                  rsp_addr_lo  <= req_addr[1:0];
                  rsp_mem_read <= w_is_load;
                  rsp_rdata    <= 32'h0;
                  misalign     <= w_misalign;
                  bus_err      <= 1'b0;
                  dm_addr      <= {req_addr[31:2], 2'b00};
                  dm_we        <= w_is_store;
                  dm_wstrb     <= w_wstrb;
                  dm_wdata     <= w_wdata;
                  if (w_misalign) begin
                     // No memory traffic: report straight away.
                     r_state   <= ST_RSP;
                     rsp_valid <= 1'b1;
                  end else begin
                     r_state <= ST_REQ;
                     dm_req  <= 1'b1;
                  end
               end
            end

            ST_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               // A grant on the final cycle still wins: memory has taken it.
               if (dm_gnt) begin
                  dm_req <= 1'b0;
                  if (rsp_mem_read) begin
                     r_state <= ST_WAIT;
                  end else begin
                     r_state   <= ST_RSP;
                     rsp_valid <= 1'b1;
                  end
               end else if (w_timeout) begin
                  dm_req    <= 1'b0;
                  bus_err   <= 1'b1;
                  r_state   <= ST_RSP;
                  rsp_valid <= 1'b1;
               end
            end

            ST_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (dm_rvalid) begin
                  rsp_rdata <= dm_rdata;
                  r_state   <= ST_RSP;
                  rsp_valid <= 1'b1;
               end else if (w_timeout) begin
                  bus_err   <= 1'b1;
                  r_state   <= ST_RSP;
                  rsp_valid <= 1'b1;
               end
            end

            ST_RSP: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               dm_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule : lsu_mem_ctrl
`default_nettype wire
